neuron_seq: RTL and testbench

NEURON_SEQ -- requirements
Module: neuron_seq

---
 rtl/neuron_seq.sv | 177 +++++++++++++++++
 tb/tb_neuron_seq.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_seq.sv
// neuron_seq: NNEUR neurons share one 32x32 unsigned MAC datapath.
// A NIN-element input vector is buffered once in LOAD. Each neuron is then
// evaluated over NIN COMPUTE cycles, and its saturated 32-bit result is held in EMIT.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is high only in LOAD. out_valid is high only in EMIT.
// While out_valid is high and out_ready is low, out_data and out_idx hold.
// Weight writes land only while busy is low; a write that arrives while busy is high is dropped.
module neuron_seq #(
    parameter int NIN   = 32,
    parameter int NNEUR = 4,
    parameter int AW    = $clog2(NIN * NNEUR),
    localparam int IW   = (NNEUR > 1) ? $clog2(NNEUR) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [31:0]   cfg_wdata,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_data,
    output logic [IW-1:0] out_idx,
    output logic          busy,
    output logic [1:0]    dbg_state
);

    localparam int KW = (NIN > 1) ? $clog2(NIN) : 1;
    localparam int NW = NIN * NNEUR;
    localparam logic [KW-1:0] K_LAST = KW'(NIN - 1);
    localparam logic [IW-1:0] N_LAST = IW'(NNEUR - 1);

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_COMPUTE = 2'd1,
        S_EMIT    = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [KW-1:0] i_q, i_d;
    logic [IW-1:0] n_q, n_d;
    logic [63:0]   acc_q, acc_d;
    logic [31:0]   out_data_q, out_data_d;
    logic [IW-1:0] out_idx_q, out_idx_d;
    logic [31:0]   w_q [NW];
    logic [31:0]   w_d [NW];
    logic [31:0]   in_buf_q [NIN];
    logic [31:0]   in_buf_d [NIN];

    logic [AW-1:0] w_addr;
    logic [63:0]   prod;
    logic [63:0]   acc_sum;
    logic [31:0]   acc_sat;

    // Build the MAC term for the current (neuron, input) pair, and saturate the running sum.
    always_comb begin
        w_addr  = AW'(n_q) * AW'(NIN) + AW'(i_q);
        prod    = {32'd0, in_buf_q[i_q]} * {32'd0, w_q[w_addr]};
        acc_sum = acc_q + prod;
        acc_sat = (acc_sum[63:32] != 32'd0) ? 32'hFFFF_FFFF : acc_sum[31:0];
    end

    // State register: on reset it returns to LOAD at once, so any vector or neuron in flight is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: LOAD -> COMPUTE after the last beat; COMPUTE -> EMIT after the last MAC; EMIT advances on the output handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD:    if (in_valid && k_q == K_LAST) state_d = S_COMPUTE;
            S_COMPUTE: if (i_q == K_LAST) state_d = S_EMIT;
            S_EMIT:    if (out_ready) state_d = (n_q == N_LAST) ? S_LOAD : S_COMPUTE;
            default:   state_d = S_LOAD;
        endcase
    end

    // Outputs decoded from the registered state and the registered result.
    always_comb begin
        in_ready  = (state_q == S_LOAD);
        out_valid = (state_q == S_EMIT);
        busy      = (state_q != S_LOAD) || (k_q != '0);
        out_data  = out_data_q;
        out_idx   = out_idx_q;
        dbg_state = state_q;
    end

    // Datapath next values: beat capture, MAC accumulation, result capture, index stepping and weight writes.
    always_comb begin
        k_d        = k_q;
        i_d        = i_q;
        n_d        = n_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        out_idx_d  = out_idx_q;
        w_d        = w_q;
        in_buf_d   = in_buf_q;

        if (cfg_we && !busy) begin
            w_d[cfg_addr] = cfg_wdata;
        end

        case (state_q)
            S_LOAD: begin
                if (in_valid) begin
                    in_buf_d[k_q] = in_data;
                    if (k_q == K_LAST) begin
                        k_d   = '0;
                        n_d   = '0;
                        i_d   = '0;
                        acc_d = '0;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            S_COMPUTE: begin
                acc_d = acc_sum;
                if (i_q == K_LAST) begin
                    i_d        = '0;
                    out_data_d = acc_sat;
                    out_idx_d  = n_q;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    acc_d = '0;
                    i_d   = '0;
                    if (n_q == N_LAST) begin
                        n_d = '0;
                        k_d = '0;
                    end else begin
                        n_d = n_q + 1'b1;
                    end
                end
            end
            default: begin
                k_d = '0;
            end
        endcase
    end

    // Datapath registers. Reset clears the counters, the result, every weight and the input buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q        <= '0;
            i_q        <= '0;
            n_q        <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
            out_idx_q  <= '0;
            for (int j = 0; j < NW; j++) w_q[j] <= '0;
            for (int j = 0; j < NIN; j++) in_buf_q[j] <= '0;
        end else begin
            k_q        <= k_d;
            i_q        <= i_d;
            n_q        <= n_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
            out_idx_q  <= out_idx_d;
            for (int j = 0; j < NW; j++) w_q[j] <= w_d[j];
            for (int j = 0; j < NIN; j++) in_buf_q[j] <= in_buf_d[j];
        end
    end

endmodule

// File: tb/tb_neuron_seq.sv
// Bench for neuron_seq with NIN=4 and NNEUR=2. The driver pushes the expected {idx, data} pairs.
// An independent monitor pops and compares them on each output handshake. The monitor also checks
// output latency and that the outputs hold steady under backpressure.
module tb_neuron_seq;
    localparam int NIN   = 4;
    localparam int NNEUR = 2;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [31:0]   cfg_wdata;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_data;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic [0:0]    out_idx;
    logic          busy;
    logic [1:0]    dbg_state;

    neuron_seq #(.NIN(NIN), .NNEUR(NNEUR), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx),
        .busy(busy), .dbg_state(dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cycle_cnt = 0;
    always @(posedge clk) cycle_cnt++;

    int total = 0;
    int bad = 0;
    int lat_ref = 0;
    logic [32:0] exp_q[$];
    logic [31:0] w_m [NIN*NNEUR];
    logic [31:0] vec_m [NIN];
    bit rand_ready = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: a plain dot product with 64-bit wrapping, then saturation to 32 bits.
    function automatic logic [31:0] ref_neuron(input int n);
        logic [63:0] acc;
        acc = 64'd0;
        for (int i = 0; i < NIN; i++) acc = acc + 64'(vec_m[i]) * 64'(w_m[n*NIN+i]);
        return (acc > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : acc[31:0];
    endfunction

    // monitor / scoreboard
    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic [31:0] pd = '0;
    logic [0:0]  pi = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            pv = 1'b0;
        end else begin
            if (out_valid) begin
                if (!pv) begin
                    check("latency", 64'(cycle_cnt - lat_ref), 64'(NIN));
                end else if (!pr) begin
                    check("hold_data", 64'(out_data), 64'(pd));
                    check("hold_idx", 64'(out_idx), 64'(pi));
                end
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_out: got idx=%0d data=%0h expected nothing", out_idx, out_data);
                    end else begin
                        logic [32:0] e;
                        e = exp_q.pop_front();
                        check("out", 64'({out_idx, out_data}), 64'(e));
                    end
                    lat_ref = cycle_cnt + 1;
                end
            end
            pv = out_valid;
            pr = out_ready;
            pd = out_data;
            pi = out_idx;
        end
    end

    // random backpressure
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cfg_we = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        for (int a = 0; a < NIN*NNEUR; a++) w_m[a] = 32'd0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_idx", 64'(out_idx), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        check("post_rst_out_valid", 64'(out_valid), 64'd0);
        check("post_rst_busy", 64'(busy), 64'd0);
        tick();
    endtask

    task automatic wr_w(input int a, input logic [31:0] d, input bit take);
        cfg_we = 1'b1;
        cfg_addr = AW'(a);
        cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
        if (take) w_m[a] = d;
    endtask

    task automatic send_vec(input bit with_cfg, input int ca, input logic [31:0] cd);
        for (int b = 0; b < NIN; b++) begin
            int waited;
            waited = 0;
            in_valid = 1'b1;
            in_data = vec_m[b];
            if (with_cfg && b == 0) begin
                cfg_we = 1'b1;
                cfg_addr = AW'(ca);
                cfg_wdata = cd;
                w_m[ca] = cd;
            end
            @(negedge clk);
            while (!in_ready && waited < 300) begin
                waited++;
                @(negedge clk);
            end
            if (!in_ready) begin
                total++;
                bad++;
                $display("FAIL in_accept_timeout: beat %0d not accepted, required acceptance", b);
            end
            if (b == NIN-1) begin
                for (int n = 0; n < NNEUR; n++) exp_q.push_back({1'(n), ref_neuron(n)});
                lat_ref = cycle_cnt + 1;
            end
            tick();
            cfg_we = 1'b0;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int c;
        c = 0;
        while ((exp_q.size() != 0 || !in_ready || busy) && c < 1000) begin
            tick();
            c++;
        end
        if (c >= 1000) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: pending=%0d required 0", exp_q.size());
        end
    endtask

    task automatic rand_vec(input bit big);
        for (int i = 0; i < NIN; i++) vec_m[i] = big ? $urandom() : 32'($urandom_range(0, 15));
    endtask

    initial begin
        int c;
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        tick();
        do_reset();

        // all-ones weights, input 1..4 -> 10, 10
        for (int a = 0; a < 8; a++) wr_w(a, 32'd1, 1);
        vec_m = '{32'd1, 32'd2, 32'd3, 32'd4};
        send_vec(0, 0, 0);
        check("busy_in_compute", 64'(busy), 64'd1);
        check("in_ready_in_compute", 64'(in_ready), 64'd0);
        check("out_valid_in_compute", 64'(out_valid), 64'd0);
        drain();

        // per-neuron weights 2 and 3, input 5s -> 40, 60
        for (int a = 0; a < 4; a++) wr_w(a, 32'd2, 1);
        for (int a = 4; a < 8; a++) wr_w(a, 32'd3, 1);
        vec_m = '{32'd5, 32'd5, 32'd5, 32'd5};
        send_vec(0, 0, 0);
        drain();
        check("in_ready_after_last", 64'(in_ready), 64'd1);

        // saturation
        for (int a = 0; a < 8; a++) wr_w(a, 32'hFFFF_FFFF, 1);
        vec_m = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        send_vec(0, 0, 0);
        drain();

        // backpressure in EMIT for 5 cycles
        for (int a = 0; a < 8; a++) wr_w(a, 32'($urandom_range(0, 1000)), 1);
        rand_vec(0);
        out_ready = 1'b0;
        send_vec(0, 0, 0);
        c = 0;
        while (!out_valid && c < 50) begin tick(); c++; end
        check("stall_reached_emit", 64'(out_valid), 64'd1);
        repeat (5) tick();
        check("stall_valid_held", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        drain();

        // write during COMPUTE is ignored
        wr_w(0, 32'd7, 1);
        vec_m = '{32'd3, 32'd1, 32'd1, 32'd1};
        send_vec(0, 0, 0);
        wr_w(0, 32'd9, 0);
        drain();
        vec_m = '{32'd10, 32'd0, 32'd0, 32'd0};
        send_vec(0, 0, 0);
        drain();

        // cfg write together with the first beat while idle
        vec_m = '{32'd2, 32'd0, 32'd0, 32'd0};
        send_vec(1, 0, 32'd11);
        drain();

        // reset at COMPUTE i=2 discards the in-flight neuron
        for (int a = 0; a < 8; a++) wr_w(a, 32'd5, 1);
        vec_m = '{32'd1, 32'd1, 32'd1, 32'd1};
        send_vec(0, 0, 0);
        tick();
        tick();
        do_reset();
        repeat (10) tick();
        rand_vec(1);
        send_vec(0, 0, 0);
        drain();

        // randomized traffic with back-to-back vectors and random backpressure
        rand_ready = 1;
        for (int it = 0; it < 15; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                drain();
                for (int j = 0; j < 3; j++) begin
                    wr_w($urandom_range(0, 7), ($urandom_range(0, 1) != 0) ? $urandom() : 32'($urandom_range(0, 99)), 1);
                end
            end
            rand_vec($urandom_range(0, 1) != 0);
            send_vec(0, 0, 0);
        end
        drain();
        rand_ready = 0;
        out_ready = 1'b1;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

endmodule
